// File: rtl/mem_refill_master_if.sv
// mem_refill_master_if
// Handshake and bus bundle between the cache controller, the refill master
// and the memory side.
//   miss_*   : cache -> master miss request (valid/ready)
//   mem_*    : master -> memory request level, memory -> master line + strobe
//   refill_* : master -> cache refill result (valid/ready)
// Modports:
//   master : the refill master's view
//   slave  : the environment's view (cache controller + memory)

interface mem_refill_master_if;
    logic          miss_valid;
    logic [31:0]   miss_addr;
    logic          miss_ready;

    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [127:0]  mem_data;
    logic          mem_ready;

    logic          refill_valid;
    logic          refill_ready;
    logic [127:0]  refill_line;
    logic [31:0]   refill_word;
    logic [31:0]   refill_addr;
    logic          refill_err;

    modport master (
        input  miss_valid, miss_addr, mem_data, mem_ready, refill_ready,
        output miss_ready, mem_req, mem_addr,
        output refill_valid, refill_line, refill_word, refill_addr, refill_err
    );

    modport slave (
        output miss_valid, miss_addr, mem_data, mem_ready, refill_ready,
        input  miss_ready, mem_req, mem_addr,
        input  refill_valid, refill_line, refill_word, refill_addr, refill_err
    );
endinterface

// File: rtl/mem_refill_master.sv
// mem_refill_master
// I-cache refill initiator. Accepts one line miss at a time, issues a single
// line-aligned memory request, captures the 128-bit line on mem_ready and
// returns line, critical word and line address to the cache over a
// valid/ready handshake. A programmable quiet gap follows every refill.
//
// Ports:
//   clk  : single clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : mem_refill_master_if.master (miss_*, mem_*, refill_*)
// Parameters:
//   REQ_GAP        : idle cycles after a refill handshake, 0..15
//   TIMEOUT_CYCLES : request timeout in cycles, >= 1 (timeout build only)
// Build option:
//   MEM_TIMEOUT_EN : when defined, an unanswered request aborts after
//                    TIMEOUT_CYCLES and returns a zero line with refill_err=1.
//                    When undefined, REQ waits forever and refill_err is 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a miss (miss_ready=1)
// REQ   | mem_req high with the line address, waiting for mem_ready
// RESP  | refill result presented, waiting for refill_ready
// GAP   | enforced quiet time before the next miss is accepted

module mem_refill_master #(
    parameter int REQ_GAP        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_refill_master_if.master bus
);

    if (REQ_GAP < 0 || REQ_GAP > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_refill_master: REQ_GAP must be 0..15 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // The gap counter is loaded with REQ_GAP-1 and leaves GAP on reaching 0,
    // so GAP lasts exactly REQ_GAP cycles.
    localparam logic [3:0] GAP_LOAD = (REQ_GAP > 0) ? 4'(REQ_GAP - 1) : 4'd0;

    state_t        state_q, state_d;
    logic [31:0]   line_addr_q, line_addr_d;
    logic [1:0]    word_sel_q, word_sel_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          refill_valid_q, refill_valid_d;
    logic [127:0]  refill_line_q, refill_line_d;
    logic [31:0]   refill_word_q, refill_word_d;
    logic [31:0]   refill_addr_q, refill_addr_d;
    logic          timeout_hit;
    logic          unused_miss_bits;

    // Byte offset within the critical word does not matter to a line refill.
    assign unused_miss_bits = ^bus.miss_addr[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            refill_err_q, refill_err_d;

    // Counter reaching 0 while in REQ marks the end of the TIMEOUT_CYCLES-th
    // request cycle.
    assign timeout_hit = (to_cnt_q == '0);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != S_REQ && state_d == S_REQ) begin
            to_cnt_d = TO_LOAD;
        end else if (state_q == S_REQ && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q     <= '0;
            refill_err_q <= 1'b0;
        end else begin
            to_cnt_q     <= to_cnt_d;
            refill_err_q <= refill_err_d;
        end
    end

    assign bus.refill_err = refill_err_q;
`else
    assign timeout_hit    = 1'b0;
    assign bus.refill_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        word_sel_d    = word_sel_q;
        gap_cnt_d     = gap_cnt_q;
        refill_line_d = refill_line_q;
        refill_word_d = refill_word_q;
        refill_addr_d = refill_addr_q;
`ifdef MEM_TIMEOUT_EN
        refill_err_d  = refill_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.miss_valid) begin
                    line_addr_d = {bus.miss_addr[31:4], 4'b0000};
                    word_sel_d  = bus.miss_addr[3:2];
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // mem_ready has priority over a simultaneous timeout.
                if (bus.mem_ready) begin
                    refill_line_d = bus.mem_data;
                    refill_word_d = bus.mem_data[{word_sel_q, 5'd0} +: 32];
                    refill_addr_d = line_addr_q;
`ifdef MEM_TIMEOUT_EN
                    refill_err_d  = 1'b0;
`endif
                    state_d       = S_RESP;
                end else if (timeout_hit) begin
                    refill_line_d = '0;
                    refill_word_d = '0;
                    refill_addr_d = line_addr_q;
`ifdef MEM_TIMEOUT_EN
                    refill_err_d  = 1'b1;
`endif
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.refill_ready) begin
                    if (REQ_GAP > 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they line up
        // with the state they describe.
        mem_req_d      = (state_d == S_REQ);
        mem_addr_d     = (state_d == S_REQ) ? line_addr_d : 32'd0;
        refill_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            line_addr_q    <= '0;
            word_sel_q     <= '0;
            gap_cnt_q      <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            refill_valid_q <= 1'b0;
            refill_line_q  <= '0;
            refill_word_q  <= '0;
            refill_addr_q  <= '0;
        end else begin
            state_q        <= state_d;
            line_addr_q    <= line_addr_d;
            word_sel_q     <= word_sel_d;
            gap_cnt_q      <= gap_cnt_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            refill_valid_q <= refill_valid_d;
            refill_line_q  <= refill_line_d;
            refill_word_q  <= refill_word_d;
            refill_addr_q  <= refill_addr_d;
        end
    end

    assign bus.miss_ready   = (state_q == S_IDLE);
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.refill_valid = refill_valid_q;
    assign bus.refill_line  = refill_line_q;
    assign bus.refill_word  = refill_word_q;
    assign bus.refill_addr  = refill_addr_q;

endmodule

// File: tb/tb_mem_refill_master.sv
module tb_mem_refill_master;
    localparam int GAP = 2;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_refill_master_if bus ();

    mem_refill_master #(.REQ_GAP(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: plain arithmetic on the address and line.
    function automatic logic [31:0] exp_line_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFF0;
    endfunction

    function automatic logic [31:0] exp_word(input logic [127:0] line, input logic [31:0] a);
        logic [127:0] sh;
        sh = line >> (32 * ((a / 4) % 4));
        return sh[31:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_miss_ready();
        int n;
        n = 0;
        while (bus.miss_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("miss_ready_wait", bus.miss_ready, 1'b1);
    endtask

    task automatic issue_miss(input logic [31:0] a);
        wait_miss_ready();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a;
        tick();
        bus.miss_valid = 1'b0;
        bus.miss_addr  = $urandom;
        check("mem_req_rise", bus.mem_req, 1'b1);
        check("mem_addr", bus.mem_addr, exp_line_addr(a));
        check("miss_ready_busy", bus.miss_ready, 1'b0);
    endtask

    // Answer after lat further request cycles (lat=0: minimum latency).
    task automatic respond(input logic [31:0] a, input logic [127:0] line, input int lat);
        for (int i = 0; i < lat; i++) begin
            tick();
            check("mem_req_hold", bus.mem_req, 1'b1);
            check("mem_addr_hold", bus.mem_addr, exp_line_addr(a));
            check("no_early_valid", bus.refill_valid, 1'b0);
        end
        bus.mem_ready = 1'b1;
        bus.mem_data  = line;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_data  = {4{32'hDEAD_BEEF}};
    endtask

    task automatic check_refill(input logic [31:0] a, input logic [127:0] line, input logic err);
        check("mem_req_low", bus.mem_req, 1'b0);
        check("mem_addr_zero", bus.mem_addr, 32'd0);
        check("refill_valid", bus.refill_valid, 1'b1);
        check("refill_line", bus.refill_line, line);
        check("refill_word", bus.refill_word, exp_word(line, a));
        check("refill_addr", bus.refill_addr, exp_line_addr(a));
        check("refill_err", bus.refill_err, err);
        check("miss_ready_resp", bus.miss_ready, 1'b0);
    endtask

    task automatic handshake();
        bus.refill_ready = 1'b1;
        tick();
        bus.refill_ready = 1'b0;
        check("refill_valid_drop", bus.refill_valid, 1'b0);
    endtask

    initial begin
        logic [31:0]  a, a2;
        logic [127:0] line, line2;
        int           n, lat, bp;

        rst              = 1'b1;
        bus.miss_valid   = 1'b0;
        bus.miss_addr    = '0;
        bus.mem_data     = '0;
        bus.mem_ready    = 1'b0;
        bus.refill_ready = 1'b0;
        tick();
        tick();
        check("rst_miss_ready", bus.miss_ready, 1'b1);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_refill_valid", bus.refill_valid, 1'b0);
        check("rst_refill_line", bus.refill_line, 128'd0);
        check("rst_refill_word", bus.refill_word, 32'd0);
        check("rst_refill_addr", bus.refill_addr, 32'd0);
        check("rst_refill_err", bus.refill_err, 1'b0);
        rst = 1'b0;
        tick();

        // Basic refill, then backpressure with a second miss held pending.
        a     = 32'h1234_5678;
        line  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        a2    = 32'hCAFE_0014;
        line2 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        issue_miss(a);
        respond(a, line, 3);
        check_refill(a, line, 1'b0);
        check("basic_word_const", bus.refill_word, 32'h4455_6677);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_refill(a, line, 1'b0);
        end
        handshake();
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 30) begin
            n++;
            tick();
        end
        bus.miss_valid = 1'b0;
        check("bp_accept_delay", n, GAP + 1);
        check("bp_second_addr", bus.mem_addr, exp_line_addr(a2));
        respond(a2, line2, 1);
        check_refill(a2, line2, 1'b0);
        handshake();

        // Stray response while idle.
        wait_miss_ready();
        bus.mem_ready = 1'b1;
        bus.mem_data  = {4{32'hDEAD_0000}};
        tick();
        bus.mem_ready = 1'b0;
        check("stray_idle_ready", bus.miss_ready, 1'b1);
        check("stray_idle_req", bus.mem_req, 1'b0);
        check("stray_idle_valid", bus.refill_valid, 1'b0);
        check("stray_idle_line", bus.refill_line, line2);

        // Back-to-back with immediate memory answers.
        a     = 32'h0000_1F0C;
        line  = {$urandom, $urandom, $urandom, $urandom};
        a2    = 32'h8000_2008;
        line2 = {$urandom, $urandom, $urandom, $urandom};
        issue_miss(a);
        respond(a, line, 0);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a2;
        n = 1;
        check_refill(a, line, 1'b0);
        handshake();
        n++;
        while (bus.mem_req !== 1'b1 && n < 30) begin
            tick();
            if (bus.mem_req !== 1'b1) n++;
        end
        bus.miss_valid = 1'b0;
        check("b2b_low_cycles", n, GAP + 2);
        check("b2b_second_addr", bus.mem_addr, exp_line_addr(a2));
        respond(a2, line2, 0);
        check_refill(a2, line2, 1'b0);
        handshake();

        // Stray response during the gap.
        bus.mem_ready = 1'b1;
        bus.mem_data  = {4{32'hDEAD_1111}};
        tick();
        bus.mem_ready = 1'b0;
        check("stray_gap_valid", bus.refill_valid, 1'b0);
        check("stray_gap_ready", bus.miss_ready, 1'b0);
        check("stray_gap_line", bus.refill_line, line2);

`ifdef MEM_TIMEOUT_EN
        a = 32'h4444_0004;
        issue_miss(a);
        n = 1;
        while (bus.mem_req === 1'b1 && n < 100) begin
            tick();
            if (bus.mem_req === 1'b1) n++;
        end
        check("timeout_req_cycles", n, TO);
        check_refill(a, 128'd0, 1'b1);
        handshake();
        a2    = 32'h5555_000C;
        line2 = {$urandom, $urandom, $urandom, $urandom};
        issue_miss(a2);
        respond(a2, line2, TO - 1);
        check_refill(a2, line2, 1'b0);
        handshake();
`else
        a    = 32'h4444_0004;
        line = {$urandom, $urandom, $urandom, $urandom};
        issue_miss(a);
        for (int i = 0; i < 3 * TO; i++) tick();
        check("no_timeout_req", bus.mem_req, 1'b1);
        check("no_timeout_valid", bus.refill_valid, 1'b0);
        respond(a, line, 0);
        check_refill(a, line, 1'b0);
        handshake();
`endif

        // Asynchronous reset in the middle of a request.
        a = 32'h7777_0008;
        issue_miss(a);
        tick();
        check("pre_rst_req", bus.mem_req, 1'b1);
        #2 rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_data  = {4{32'hDEAD_2222}};
        #1;
        check("async_rst_req", bus.mem_req, 1'b0);
        check("async_rst_addr", bus.mem_addr, 32'd0);
        check("async_rst_valid", bus.refill_valid, 1'b0);
        check("async_rst_line", bus.refill_line, 128'd0);
        check("async_rst_word", bus.refill_word, 32'd0);
        check("async_rst_raddr", bus.refill_addr, 32'd0);
        check("async_rst_err", bus.refill_err, 1'b0);
        check("async_rst_ready", bus.miss_ready, 1'b1);
        tick();
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_valid", bus.refill_valid, 1'b0);
            check("post_rst_no_req", bus.mem_req, 1'b0);
        end
        a2    = 32'h1357_9BDC;
        line2 = {$urandom, $urandom, $urandom, $urandom};
        issue_miss(a2);
        respond(a2, line2, 2);
        check_refill(a2, line2, 1'b0);
        handshake();

        // Randomised transactions against the model.
        for (int t = 0; t < 12; t++) begin
            a    = $urandom;
            line = {$urandom, $urandom, $urandom, $urandom};
            lat  = $urandom_range(0, 4);
            bp   = $urandom_range(0, 3);
            issue_miss(a);
            respond(a, line, lat);
            check_refill(a, line, 1'b0);
            for (int i = 0; i < bp; i++) begin
                tick();
                check_refill(a, line, 1'b0);
            end
            handshake();
            if ($urandom_range(0, 1) == 1) begin
                bus.mem_ready = 1'b1;
                bus.mem_data  = {4{32'hDEAD_3333}};
                tick();
                bus.mem_ready = 1'b0;
                check("rand_stray_valid", bus.refill_valid, 1'b0);
                check("rand_stray_line", bus.refill_line, line);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_refill_master.md
# mem_refill_master

Memory-side refill initiator for the I-cache. It accepts one line-miss request at a time from the cache controller and drives the `mem_req`/`mem_addr` request interface toward the memory model (`mem_sim`) or the real memory port. It captures the 128-bit line returned with `mem_ready` and hands the line, plus the critical 32-bit word, back to the cache over a valid/ready handshake. It is the synthesizable counterpart of the stimulus that currently drives the memory model in simulation.

## Interface
- `REQ_GAP`, default 2: minimum cycles `mem_req` stays low between two consecutive memory requests; legal range 0..15.
- `TIMEOUT_CYCLES`, default 64: cycles to wait for `mem_ready` before aborting; used only with `MEM_TIMEOUT_EN`; must be ≥ 1.
- `clk` in 1: single clock; all logic on the posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `miss_valid` in 1: the cache presents a miss.
- `miss_addr` in 32: byte address of the missing fetch.
- `miss_ready` out 1: the block can accept a miss.
- `mem_req` out 1: memory request, a registered level.
- `mem_addr` out 32: line-aligned request address.
- `mem_data` in 128: line data, valid in any cycle where `mem_ready`=1.
- `mem_ready` in 1: memory response strobe.
- `refill_valid` out 1: the refill result is available.
- `refill_ready` in 1: the cache accepts the refill.
- `refill_line` out 128: the captured line.
- `refill_word` out 32: the critical word, `refill_line[32*k +: 32]` with k = `miss_addr[3:2]`.
- `refill_addr` out 32: line-aligned address of the refill.
- `refill_err` out 1: the refill was aborted; constant 0 when the timeout feature is compiled out.

## Operation
- The state machine has four states: IDLE, REQ, RESP, GAP. It resets to IDLE.
- **IDLE**
  - `miss_ready`=1 in this state only.
  - On `miss_valid && miss_ready`: latch `{miss_addr[31:4],4'b0}` as the line address and latch `miss_addr[3:2]`; go to REQ.
- **REQ**
  - `mem_req`=1 and `mem_addr` = the line address, both held stable for the whole state.
  - When `mem_ready`=1 at a posedge: capture `mem_data` into `refill_line`, clear `refill_err`, go to RESP.
  - With `MEM_TIMEOUT_EN` defined, the timeout counter runs in this state. When it reaches `TIMEOUT_CYCLES`: set `refill_line`=0 and `refill_err`=1, go to RESP.
  - If `mem_ready` and the timeout occur in the same cycle, `mem_ready` wins (no error).
- **RESP**
  - `mem_req`=0 and `mem_addr`=0.
  - `refill_valid`=1, with `refill_line`, `refill_word`, `refill_addr` and `refill_err` held stable.
  - On `refill_ready`: go to GAP if `REQ_GAP`>0, else go to IDLE.
- **GAP**
  - A counter counts `REQ_GAP` cycles, then the state goes to IDLE.
  - `miss_ready`=0 during GAP.
- `mem_ready` is ignored outside REQ. A stray or late pulse does not capture data or change state.
- `miss_valid` is ignored outside IDLE. The cache holds the miss until `miss_ready`.
- Address rule: `mem_addr[3:0]` is always 0. No address arithmetic wraps, because one line is one beat.
- When `rst` asserts in any state:
  - `mem_req` drops immediately (asynchronously).
  - All state and counters clear.
  - The in-flight request is abandoned; no refill is produced for it.

## Timing
- Reset values: `miss_ready`=1, `mem_req`=0, `mem_addr`=0, `refill_valid`=0, `refill_line`=0, `refill_word`=0, `refill_addr`=0, `refill_err`=0.
- A miss accepted at edge T gives `mem_req`=1 from T+1.
- `mem_ready` sampled at edge R gives `mem_req`=0 and `refill_valid`=1 from R+1.
- Minimum request-to-response latency is 1 cycle: `mem_req` rises at T+1, `mem_ready` is sampled at T+2, and `refill_valid` rises at T+3.
- Refill handshake at edge H gives `refill_valid`=0 at H+1. `miss_ready`=1 at H+1+`REQ_GAP`.
- Back-to-back spacing:
  - With `REQ_GAP`=0, the next `mem_req` rises 2 cycles after H.
  - Every request has ≥ `REQ_GAP`+2 low cycles of `mem_req` between pulses.
- Timeout: with `mem_req` rising at cycle 1 of REQ and no `mem_ready`, `mem_req` falls after exactly `TIMEOUT_CYCLES` high cycles.
- All outputs are registered. There is no combinational path from any input to any output except `miss_ready`, which is decoded from state only.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - The REQ timeout counter and the `refill_err` generation are compiled in.
  - An unanswered request aborts after `TIMEOUT_CYCLES` and returns an error refill.
- Not defined:
  - No counter is built, and REQ waits for `mem_ready` indefinitely.
  - `refill_err` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- **Basic refill:** miss at `miss_addr`=0x1234_5678; mem responds 3 cycles after `mem_req` with line 0x0011..FF.
  - Required: `mem_addr`=0x1234_5670 held for the whole request.
  - Required: `refill_line` = that line, `refill_word` = `line[95:64]` (k=2), `refill_addr`=0x1234_5670, `refill_err`=0.
- **Backpressure:** hold `refill_ready`=0 for 5 cycles after `refill_valid`.
  - Required: outputs stay stable, `miss_ready`=0, and a second `miss_valid` is not accepted until handshake + `REQ_GAP`.
- **Back-to-back with `REQ_GAP`=2:** two misses, memory answers immediately.
  - Required: `mem_req` low for ≥4 cycles between pulses, and the second `mem_addr` is correct.
- **Stray response:** pulse `mem_ready` with data 0xDEAD.. while in IDLE and again in GAP.
  - Required: no state change and no `refill_valid`.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** the memory never answers.
  - Required: `mem_req` is high for exactly 8 cycles, then `refill_valid`=1, `refill_err`=1, `refill_line`=0.
  - Required: `mem_ready` coinciding with cycle 8 returns data with `refill_err`=0.
- **Reset mid-REQ:** assert `rst` asynchronously between edges while `mem_req`=1.
  - Required: `mem_req` falls immediately and all outputs return to reset values.
  - Required: after release, a new miss completes normally with no refill from the abandoned request.
